pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor. It generalises our 4-bit CLA to WIDTH bits.
- The operand is split into BLOCK-bit lookahead groups; one group is resolved per pipeline stage, and the group carry is registered between stages.
- Adds a subtract mode, a signed-overflow flag and valid/ready handshakes on input and output, so it can sit in a streaming datapath at one operation per clock.

---
 rtl/pipelined_cla_adder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Streaming WIDTH-bit adder/subtractor. The operands are split into BLOCK-bit
//   carry-lookahead groups, and one group is resolved per pipeline stage. The
//   group carry is registered between stages. Throughput is one operation per
//   clock and latency is NSTAGE = WIDTH/BLOCK cycles.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   IN_VALID / IN_READY  input handshake for A, B, C_IN, SUB
//   A, B                 operands
//   C_IN                 carry-in, ignored when SUB=1
//   SUB                  0: A+B+C_IN, 1: A-B (= A+~B+1)
//   OUT_VALID/OUT_READY  output handshake
//   SUM, C_OUT, OVF      result, carry out of MSB (1 = no borrow on SUB),
//                        two's-complement overflow
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT,
    output logic             OVF
);
    localparam int NSTAGE = WIDTH / BLOCK;

    // One BLOCK-bit lookahead group.
    // Returns {carry out, carry into the top bit, sum}.
    // Each carry is an independent OR of generate terms gated by the
    // propagates above them, so nothing ripples inside the group.
    function automatic logic [BLOCK+1:0] cla_grp(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             ci);
        logic [BLOCK-1:0] g, p, s;
        logic [BLOCK:0]   c;
        logic             pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        s = p ^ c[BLOCK-1:0];
        return {c[BLOCK], c[BLOCK-1], s};
    endfunction

    logic adv;

    // Stage inputs: stage 1 reads the ports, and stage k reads stage k-1.
    logic [NSTAGE:1] vin;
    logic [NSTAGE:1] cin_w;
    logic [WIDTH-1:0] ain [1:NSTAGE];
    logic [WIDTH-1:0] bin [1:NSTAGE];
    logic [WIDTH-1:0] sin [1:NSTAGE];

    // Next-state values and stage registers.
    // a_q/b_q carry operand bits that later stages have not consumed yet.
    logic [WIDTH-1:0] sum_d [1:NSTAGE];
    logic [NSTAGE:1]  cy_d;
    logic             ovf_d [1:NSTAGE];
    logic [NSTAGE:1]  vld_q;
    logic [NSTAGE:1]  cy_q;
    logic [WIDTH-1:0] sum_q [1:NSTAGE];
    logic [WIDTH-1:0] a_q   [1:NSTAGE];
    logic [WIDTH-1:0] b_q   [1:NSTAGE];
    logic             ovf_q [1:NSTAGE];

    // The whole pipeline moves together. Bubbles are not squeezed out.
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = RST_N && adv;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
        localparam int LO = (k - 1) * BLOCK;
        logic [BLOCK+1:0] grp;

        if (k == 1) begin : g_first
            // Subtraction: B is inverted here and the carry-in is forced to 1.
            assign vin[k]   = IN_VALID;
            assign ain[k]   = A;
            assign bin[k]   = SUB ? ~B : B;
            assign cin_w[k] = SUB | C_IN;
            assign sin[k]   = '0;
        end else begin : g_next
            assign vin[k]   = vld_q[k-1];
            assign ain[k]   = a_q[k-1];
            assign bin[k]   = b_q[k-1];
            assign cin_w[k] = cy_q[k-1];
            assign sin[k]   = sum_q[k-1];
        end

        assign grp = cla_grp(ain[k][LO +: BLOCK], bin[k][LO +: BLOCK], cin_w[k]);
        // Sum bits above this group are still zero, so OR-ing in the group is safe.
        assign sum_d[k] = sin[k] | (WIDTH'(grp[BLOCK-1:0]) << LO);
        assign cy_d[k]  = grp[BLOCK+1];
        // Only the last stage's value reaches OVF: carry-in(MSB) ^ carry-out(MSB).
        assign ovf_d[k] = grp[BLOCK+1] ^ grp[BLOCK];
    end

    // Data registers load only for valid operations. This keeps the outputs
    // at 0 from reset until the first real result arrives.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                ovf_q[k] <= 1'b0;
            end
        end else if (adv) begin
            vld_q <= vin;
            for (int k = 1; k <= NSTAGE; k++) begin
                if (vin[k]) begin
                    sum_q[k] <= sum_d[k];
                    a_q[k]   <= ain[k];
                    b_q[k]   <= bin[k];
                    cy_q[k]  <= cy_d[k];
                    ovf_q[k] <= ovf_d[k];
                end
            end
        end
    end

    assign OUT_VALID = vld_q[NSTAGE];
    assign SUM       = sum_q[NSTAGE];
    assign C_OUT     = cy_q[NSTAGE];
    assign OVF       = ovf_q[NSTAGE];

endmodule
